sprite_engine: RTL and testbench
================================

// Module: sprite_engine
// PURPOSE
// - Parametrised video object generator: NUM_OBJECTS sprites, register-mapped, fed by the hdmi hpos/vpos beam counters.
// - Each object has its own X/Y position, height, 8-bit graphics, reflection, horizontal stretch and colour.
// - Emits a prioritised pixel colour and sticky pairwise collision latches, with an optional interrupt.
// - Sits between the peripheral register bus and the video colour mux; replaces the fixed player/missile/ball set.
// PARAMETERS
// NUM_OBJECTS  4   number of sprites, legal 2..8
// POS_WIDTH    10  width of hpos/vpos/posx/posy
// COLOR_WIDTH  7   width of object colour and pixel_color
// PORTS
// clk               in   1            pixel clock; all state on posedge
// reset_n           in   1            asynchronous, active-low reset
// hpos              in   POS_WIDTH    current beam column
// vpos              in   POS_WIDTH    current beam line
// in_image          in   1            beam in visible area
// reg_write_enable  in   1            one-cycle register write strobe
// reg_read_strobe   in   1            one-cycle register read strobe
// reg_address       in   8            register address
// reg_data_in       in   8            write data
// reg_data_out      out  8            read data, registered
// pixel_valid       out  1            some object covers this pixel
// pixel_color       out  COLOR_WIDTH  colour of highest-priority object, else 0
// collision_irq     out  1            (collision latches != 0) && irq_enable
// BEHAVIOUR
// - Reset: every output is 0; all object registers, shifters, collision latches and irq_enable are 0.
// - Register map, object n at base n*8:
//   - +0/+1 posx lo/hi[1:0]; +2/+3 posy lo/hi[1:0]; +4 height (0 = never drawn); +5 graphics
//   - +6 ctrl {enable[7], reflect[3], width[1:0]}; +7 colour = data[7:1]
// - Global registers:
//   - 0x40..0x43 collision latches, bytes 0..3 (RO)
//   - 0x44 write: clear all latches
//   - 0x45 irq_enable[0]
// - Objects n >= NUM_OBJECTS and unmapped addresses: read 0, writes ignored.
// - Reads: reg_data_out updates on the clock edge after reg_read_strobe and holds until the next read.
// - Vertical match: posy <= vpos < posy+height, sum computed in POS_WIDTH+1 bits, no wrap.
// - Strobe: enable && vertical match && hpos==posx && in_image.
//   - On strobe the object loads graphics, bit-reversed if reflect, into its shifter.
//   - Graphics, reflect and width are sampled at the strobe; writes mid-line take effect at the next strobe.
// - Shifting: each bit is held 2^width clocks (1/2/4/8), then the next bit; MSB first; 8 bits in total.
//   - The object is active while bits remain.
// - Strobe during an active shift restarts the object from bit 7.
// - in_image low: all shifters abort to idle on the next edge.
// - Latency: pixel for beam column X is driven on pixel_color exactly 2 clocks after hpos==X.
//   - Stage 1: strobe/shift. Stage 2: priority/collision register.
// - Priority: the lowest object index whose current bit is 1 wins.
// - Collision pair (i<j) maps to latch bit j*(j-1)/2+i.
//   - A bit sets when both objects have a 1 bit in the same cycle.
//   - Latches are sticky; reads do not clear them.
// - Clear write (0x44) in the same cycle as a new collision: the latch ends set (set wins).
// - reset_n low at any time, mid-line or mid-shift: immediate return to reset state.
// TESTING
// - Obj0 posx=100, posy=50, height=4, gfx=0xA5, width=0, enable, colour 0x55 (write 0xAA).
//   - On lines 50..53, pixel_valid at cols 100..107 = 1,0,1,0,0,1,0,1, colour 0x55.
//   - Lines 49 and 54 stay blank.
// - Same object with width=2 and reflect=1: each bit lasts 4 pixels over 32 columns, pattern reversed to 0xA5 reflected.
// - Obj0 and obj1 both gfx=0xFF at posx 200/204, colours 0x11/0x22:
//   - cols 200..203 = 0x11; 204..207 = 0x11 (obj0 wins); 208..211 = 0x22.
//   - Reading 0x40 returns 0x01.
// - With irq_enable=1 after a collision, collision_irq=1.
//   - Write 0x44 in a frame with no overlap: read 0x40 = 0, irq=0.
//   - Write 0x44 in the same cycle as an overlap: bit stays 1.
// - Rewrite obj0 posx to 300 mid-shift:
//   - the current 8 bits complete at the old position;
//   - a second strobe at posx restarts from bit 7;
//   - reset_n pulse mid-shift: outputs 0 asynchronously.
// - Unmapped/unused addresses: read 0x38 (obj7 with NUM_OBJECTS=4) and 0x7F, both return 0; a write to 0x3E changes no output.

Source files
------------

// File: rtl/sprite_engine.sv
// Register-mapped sprite generator: per-object shifters feed a priority colour mux and sticky pairwise collision latches.
// Two-stage pipeline (strobe/shift, then priority/collision) with no backpressure; register accesses complete in one cycle.
module sprite_engine #(
    parameter int NUM_OBJECTS = 4,
    parameter int POS_WIDTH   = 10,
    parameter int COLOR_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [POS_WIDTH-1:0]   hpos,
    input  logic [POS_WIDTH-1:0]   vpos,
    input  logic                   in_image,
    input  logic                   reg_write_enable,
    input  logic                   reg_read_strobe,
    input  logic [7:0]             reg_address,
    input  logic [7:0]             reg_data_in,
    output logic [7:0]             reg_data_out,
    output logic                   pixel_valid,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    output logic                   collision_irq
);

    localparam int PW1 = POS_WIDTH + 1;

    typedef struct packed {
        logic [POS_WIDTH-1:0]   posx;
        logic [POS_WIDTH-1:0]   posy;
        logic [7:0]             height;
        logic [7:0]             gfx;
        logic                   enable;
        logic                   reflect;
        logic [1:0]             width;
        logic [COLOR_WIDTH-1:0] color;
    } obj_t;

    typedef struct packed {
        logic [7:0] bits;
        logic [3:0] left;
        logic [2:0] hold;
        logic [1:0] width;
    } shift_t;

    obj_t                   obj_q [NUM_OBJECTS];
    obj_t                   obj_d [NUM_OBJECTS];
    shift_t                 shf_q [NUM_OBJECTS];
    shift_t                 shf_d [NUM_OBJECTS];
    logic [31:0]            coll_q, coll_d;
    logic                   irq_en_q, irq_en_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   pix_vld_q, pix_vld_d;
    logic [COLOR_WIDTH-1:0] pix_col_q, pix_col_d;
    logic                   clr_latch;
    logic [NUM_OBJECTS-1:0] strobe;
    logic [NUM_OBJECTS-1:0] cur_bit;
    logic [31:0]            hit;

    // Position registers are split into byte lanes; upper lane keeps only the bits that exist.
    function automatic logic [POS_WIDTH-1:0] put_byte(input logic [POS_WIDTH-1:0] old,
                                                      input logic hi, input logic [7:0] d);
        logic [15:0] t;
        t = 16'(old);
        if (hi) t[15:8] = d;
        else    t[7:0]  = d;
        return t[POS_WIDTH-1:0];
    endfunction

    function automatic logic [7:0] get_byte(input logic [POS_WIDTH-1:0] v, input logic hi);
        logic [15:0] t;
        t = 16'(v);
        return hi ? t[15:8] : t[7:0];
    endfunction

    function automatic logic [7:0] bitrev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    function automatic logic [2:0] hold_max(input logic [1:0] w);
        return 3'((4'd1 << w) - 4'd1);
    endfunction

    always_comb begin
        irq_en_d  = irq_en_q;
        clr_latch = 1'b0;
        for (int n = 0; n < NUM_OBJECTS; n++) begin
            obj_d[n] = obj_q[n];
            if (reg_write_enable && reg_address[7:6] == 2'b00 && reg_address[5:3] == 3'(n)) begin
                case (reg_address[2:0])
                    3'd0: obj_d[n].posx   = put_byte(obj_q[n].posx, 1'b0, reg_data_in);
                    3'd1: obj_d[n].posx   = put_byte(obj_q[n].posx, 1'b1, reg_data_in);
                    3'd2: obj_d[n].posy   = put_byte(obj_q[n].posy, 1'b0, reg_data_in);
                    3'd3: obj_d[n].posy   = put_byte(obj_q[n].posy, 1'b1, reg_data_in);
                    3'd4: obj_d[n].height = reg_data_in;
                    3'd5: obj_d[n].gfx    = reg_data_in;
                    3'd6: begin
                        obj_d[n].enable  = reg_data_in[7];
                        obj_d[n].reflect = reg_data_in[3];
                        obj_d[n].width   = reg_data_in[1:0];
                    end
                    default: obj_d[n].color = COLOR_WIDTH'(reg_data_in[7:1]);
                endcase
            end
        end
        if (reg_write_enable && reg_address == 8'h44) clr_latch = 1'b1;
        if (reg_write_enable && reg_address == 8'h45) irq_en_d = reg_data_in[0];
    end

    always_comb begin
        rdata_d = rdata_q;
        if (reg_read_strobe) begin
            rdata_d = 8'h00;
            for (int n = 0; n < NUM_OBJECTS; n++) begin
                if (reg_address[7:6] == 2'b00 && reg_address[5:3] == 3'(n)) begin
                    case (reg_address[2:0])
                        3'd0:    rdata_d = get_byte(obj_q[n].posx, 1'b0);
                        3'd1:    rdata_d = get_byte(obj_q[n].posx, 1'b1);
                        3'd2:    rdata_d = get_byte(obj_q[n].posy, 1'b0);
                        3'd3:    rdata_d = get_byte(obj_q[n].posy, 1'b1);
                        3'd4:    rdata_d = obj_q[n].height;
                        3'd5:    rdata_d = obj_q[n].gfx;
                        3'd6:    rdata_d = {obj_q[n].enable, 3'b000, obj_q[n].reflect, 1'b0, obj_q[n].width};
                        default: rdata_d = 8'({obj_q[n].color, 1'b0});
                    endcase
                end
            end
            case (reg_address)
                8'h40:   rdata_d = coll_q[7:0];
                8'h41:   rdata_d = coll_q[15:8];
                8'h42:   rdata_d = coll_q[23:16];
                8'h43:   rdata_d = coll_q[31:24];
                8'h45:   rdata_d = {7'd0, irq_en_q};
                default: ;
            endcase
        end
    end

    // Stage 1: a strobe always restarts from bit 7, even mid-shift; leaving the visible area kills every shifter.
    always_comb begin
        strobe  = '0;
        cur_bit = '0;
        for (int n = 0; n < NUM_OBJECTS; n++) begin
            shf_d[n]   = shf_q[n];
            cur_bit[n] = (shf_q[n].left != 4'd0) && shf_q[n].bits[7];
            strobe[n]  = obj_q[n].enable && in_image && (hpos == obj_q[n].posx) &&
                         ({1'b0, vpos} >= {1'b0, obj_q[n].posy}) &&
                         ({1'b0, vpos} < ({1'b0, obj_q[n].posy} + PW1'(obj_q[n].height)));
            if (!in_image) begin
                shf_d[n].left = 4'd0;
            end else if (strobe[n]) begin
                shf_d[n].bits  = obj_q[n].reflect ? bitrev(obj_q[n].gfx) : obj_q[n].gfx;
                shf_d[n].left  = 4'd8;
                shf_d[n].hold  = 3'd0;
                shf_d[n].width = obj_q[n].width;
            end else if (shf_q[n].left != 4'd0) begin
                if (shf_q[n].hold == hold_max(shf_q[n].width)) begin
                    shf_d[n].bits = {shf_q[n].bits[6:0], 1'b0};
                    shf_d[n].left = shf_q[n].left - 4'd1;
                    shf_d[n].hold = 3'd0;
                end else begin
                    shf_d[n].hold = shf_q[n].hold + 3'd1;
                end
            end
        end
    end

    // Stage 2: lowest index wins; a clear in the same cycle as a hit leaves the hit set.
    always_comb begin
        pix_vld_d = |cur_bit;
        pix_col_d = '0;
        hit       = '0;
        for (int n = NUM_OBJECTS - 1; n >= 0; n--) begin
            if (cur_bit[n]) pix_col_d = obj_q[n].color;
        end
        for (int j = 1; j < NUM_OBJECTS; j++) begin
            for (int i = 0; i < j; i++) begin
                if (cur_bit[i] && cur_bit[j]) hit[5'(j * (j - 1) / 2 + i)] = 1'b1;
            end
        end
        coll_d = (clr_latch ? 32'd0 : coll_q) | hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < NUM_OBJECTS; n++) begin
                obj_q[n] <= '0;
                shf_q[n] <= '0;
            end
            coll_q    <= '0;
            irq_en_q  <= 1'b0;
            rdata_q   <= '0;
            pix_vld_q <= 1'b0;
            pix_col_q <= '0;
        end else begin
            for (int n = 0; n < NUM_OBJECTS; n++) begin
                obj_q[n] <= obj_d[n];
                shf_q[n] <= shf_d[n];
            end
            coll_q    <= coll_d;
            irq_en_q  <= irq_en_d;
            rdata_q   <= rdata_d;
            pix_vld_q <= pix_vld_d;
            pix_col_q <= pix_col_d;
        end
    end

    assign reg_data_out  = rdata_q;
    assign pixel_valid   = pix_vld_q;
    assign pixel_color   = pix_col_q;
    assign collision_irq = (coll_q != 32'd0) && irq_en_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed scenarios plus randomized objects/writes, checked every cycle
// against a timing model that derives each object's current bit from the cycles elapsed since its strobe.
module tb_sprite_engine;

    localparam int NOBJ = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] hpos, vpos;
    logic       in_image;
    logic       reg_write_enable, reg_read_strobe;
    logic [7:0] reg_address, reg_data_in, reg_data_out;
    logic       pixel_valid;
    logic [6:0] pixel_color;
    logic       collision_irq;

    sprite_engine #(.NUM_OBJECTS(NOBJ), .POS_WIDTH(10), .COLOR_WIDTH(7)) dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .in_image(in_image),
        .reg_write_enable(reg_write_enable), .reg_read_strobe(reg_read_strobe),
        .reg_address(reg_address), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .pixel_valid(pixel_valid), .pixel_color(pixel_color), .collision_irq(collision_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0]  m_posx [NOBJ];
    logic [9:0]  m_posy [NOBJ];
    logic [7:0]  m_h    [NOBJ];
    logic [7:0]  m_gfx  [NOBJ];
    logic        m_en   [NOBJ];
    logic        m_refl [NOBJ];
    logic [1:0]  m_w    [NOBJ];
    logic [6:0]  m_col  [NOBJ];
    bit          m_act  [NOBJ];
    int          m_start[NOBJ];
    logic [7:0]  m_g    [NOBJ];
    int          m_sw   [NOBJ];
    bit          mb     [NOBJ];
    logic [31:0] m_lat;
    logic [31:0] newh;
    logic        m_irq_en;
    int          cyc;
    logic        exp_vld;
    logic [6:0]  exp_col;
    logic [7:0]  exp_rdata;

    function automatic bit obj_bit(input int n);
        int k;
        if (!m_act[n]) return 1'b0;
        k = (cyc - m_start[n]) >> m_sw[n];
        if (k >= 8) return 1'b0;
        return m_g[n][7-k];
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int n;
        n = int'(a[5:3]);
        if (a < 8'h40) begin
            if (n >= NOBJ) return 8'h00;
            case (a[2:0])
                3'd0: return m_posx[n][7:0];
                3'd1: return {6'd0, m_posx[n][9:8]};
                3'd2: return m_posy[n][7:0];
                3'd3: return {6'd0, m_posy[n][9:8]};
                3'd4: return m_h[n];
                3'd5: return m_gfx[n];
                3'd6: return {m_en[n], 3'd0, m_refl[n], 1'b0, m_w[n]};
                default: return {m_col[n], 1'b0};
            endcase
        end
        case (a)
            8'h40: return m_lat[7:0];
            8'h41: return m_lat[15:8];
            8'h42: return m_lat[23:16];
            8'h43: return m_lat[31:24];
            8'h45: return {7'd0, m_irq_en};
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
        int n;
        n = int'(a[5:3]);
        if (a == 8'h45) m_irq_en = d[0];
        if (a >= 8'h40 || n >= NOBJ) return;
        case (a[2:0])
            3'd0: m_posx[n][7:0] = d;
            3'd1: m_posx[n][9:8] = d[1:0];
            3'd2: m_posy[n][7:0] = d;
            3'd3: m_posy[n][9:8] = d[1:0];
            3'd4: m_h[n] = d;
            3'd5: m_gfx[n] = d;
            3'd6: begin m_en[n] = d[7]; m_refl[n] = d[3]; m_w[n] = d[1:0]; end
            default: m_col[n] = d[7:1];
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < NOBJ; n++) begin
                m_posx[n] = 0; m_posy[n] = 0; m_h[n] = 0; m_gfx[n] = 0; m_en[n] = 0;
                m_refl[n] = 0; m_w[n] = 0; m_col[n] = 0; m_act[n] = 0; m_start[n] = 0;
                m_g[n] = 0; m_sw[n] = 0;
            end
            m_lat = 0; m_irq_en = 0; cyc = 0; exp_vld = 0; exp_col = 0; exp_rdata = 0;
        end else begin
            if (reg_read_strobe) exp_rdata = model_read(reg_address);
            for (int n = 0; n < NOBJ; n++) mb[n] = obj_bit(n);
            exp_vld = 1'b0;
            exp_col = 7'd0;
            for (int n = NOBJ - 1; n >= 0; n--) if (mb[n]) begin exp_vld = 1'b1; exp_col = m_col[n]; end
            newh = 32'd0;
            for (int j = 1; j < NOBJ; j++)
                for (int i = 0; i < j; i++)
                    if (mb[i] && mb[j]) newh[j*(j-1)/2+i] = 1'b1;
            if (reg_write_enable && reg_address == 8'h44) m_lat = 32'd0;
            m_lat = m_lat | newh;
            cyc++;
            for (int n = 0; n < NOBJ; n++) begin
                if (!in_image) m_act[n] = 1'b0;
                else if (m_en[n] && int'(hpos) == int'(m_posx[n]) && int'(vpos) >= int'(m_posy[n]) &&
                         int'(vpos) < int'(m_posy[n]) + int'(m_h[n])) begin
                    m_act[n]   = 1'b1;
                    m_start[n] = cyc;
                    m_sw[n]    = int'(m_w[n]);
                    for (int b = 0; b < 8; b++) m_g[n][b] = m_refl[n] ? m_gfx[n][7-b] : m_gfx[n][b];
                end
            end
            if (reg_write_enable) model_write(reg_address, reg_data_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("pix_vld@%0d", cyc), 32'(pixel_valid), 32'(exp_vld));
            check($sformatf("pix_col@%0d", cyc), 32'(pixel_color), 32'(exp_col));
            check($sformatf("irq@%0d", cyc), 32'(collision_irq), 32'((m_lat != 0) && m_irq_en));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic       cap_vld [1024];
    logic [6:0] cap_col [1024];

    task automatic reg_wr(input int a, input int d);
        @(negedge clk);
        reg_write_enable = 1'b1; reg_address = 8'(a); reg_data_in = 8'(d);
        @(negedge clk);
        reg_write_enable = 1'b0;
    endtask

    task automatic reg_rd(input int a, output logic [7:0] d);
        @(negedge clk);
        reg_read_strobe = 1'b1; reg_address = 8'(a);
        @(negedge clk);
        reg_read_strobe = 1'b0;
        d = reg_data_out;
        check($sformatf("rd_%02h", a), 32'(d), 32'(exp_rdata));
    endtask

    task automatic set_obj(input int n, input int x, input int y, input int h, input int g,
                           input int ctrl, input int colwr);
        reg_wr(n*8+0, x & 8'hFF); reg_wr(n*8+1, x >> 8);
        reg_wr(n*8+2, y & 8'hFF); reg_wr(n*8+3, y >> 8);
        reg_wr(n*8+4, h); reg_wr(n*8+5, g); reg_wr(n*8+6, ctrl); reg_wr(n*8+7, colwr);
    endtask

    // Output for column h-2 is visible at the negedge where column h would be driven.
    task automatic scan_line(input int v, input int h0, input int h1, input int c1, input int a1,
                             input int d1, input int c2, input int a2, input int d2, input bit gaps);
        for (int h = h0; h <= h1 + 2; h++) begin
            @(negedge clk);
            if (h - 2 >= h0) begin cap_vld[h-2] = pixel_valid; cap_col[h-2] = pixel_color; end
            hpos = 10'(h); vpos = 10'(v);
            in_image = (h <= h1) && !(gaps && $urandom_range(0, 19) == 0);
            reg_write_enable = 1'b0;
            if (h == c1) begin reg_write_enable = 1'b1; reg_address = 8'(a1); reg_data_in = 8'(d1); end
            if (h == c2) begin reg_write_enable = 1'b1; reg_address = 8'(a2); reg_data_in = 8'(d2); end
        end
        @(negedge clk);
        in_image = 1'b0; reg_write_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, pat;
        int cnt;
        reset_n = 1'b0; hpos = 0; vpos = 0; in_image = 0;
        reg_write_enable = 0; reg_read_strobe = 0; reg_address = 0; reg_data_in = 0;
        repeat (3) @(negedge clk);
        check("rst_vld", 32'(pixel_valid), 0);
        check("rst_col", 32'(pixel_color), 0);
        check("rst_irq", 32'(collision_irq), 0);
        check("rst_rdata", 32'(reg_data_out), 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        reg_rd(8'h45, rd); check("rst_irq_en", 32'(rd), 0);

        // Basic object, width 1
        pat = 8'hA5;
        set_obj(0, 100, 50, 4, 8'hA5, 8'h80, 8'hAA);
        reg_rd(8'h07, rd); check("col_rd", 32'(rd), 32'hAA);
        for (int v = 49; v <= 54; v++) begin
            scan_line(v, 95, 115, -1, 0, 0, -1, 0, 0, 1'b0);
            if (v == 49 || v == 54) begin
                cnt = 0;
                for (int c = 95; c <= 115; c++) cnt += int'(cap_vld[c]);
                check($sformatf("blank_l%0d", v), 32'(cnt), 0);
            end else begin
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("t1_l%0d_c%0d", v, 100 + k), 32'(cap_vld[100+k]), 32'(pat[7-k]));
                    if (pat[7-k]) check($sformatf("t1_col_c%0d", 100 + k), 32'(cap_col[100+k]), 32'h55);
                end
                check($sformatf("t1_l%0d_c108", v), 32'(cap_vld[108]), 0);
            end
        end

        // Width 2 (4 clocks per bit) with reflect
        reg_wr(8'h06, 8'h8A);
        scan_line(50, 95, 140, -1, 0, 0, -1, 0, 0, 1'b0);
        for (int c = 100; c < 132; c++)
            check($sformatf("t2_c%0d", c), 32'(cap_vld[c]), 32'(pat[(c - 100) / 4]));
        check("t2_c132", 32'(cap_vld[132]), 0);

        // Overlap, priority and collision
        set_obj(0, 200, 50, 4, 8'hFF, 8'h80, 8'h22);
        set_obj(1, 204, 50, 4, 8'hFF, 8'h80, 8'h44);
        reg_wr(8'h44, 0);
        scan_line(50, 195, 215, -1, 0, 0, -1, 0, 0, 1'b0);
        for (int c = 200; c < 212; c++) begin
            check($sformatf("t3_vld_c%0d", c), 32'(cap_vld[c]), 1);
            check($sformatf("t3_col_c%0d", c), 32'(cap_col[c]), (c < 208) ? 32'h11 : 32'h22);
        end
        check("t3_c212", 32'(cap_vld[212]), 0);
        reg_rd(8'h40, rd); check("t3_lat", 32'(rd), 32'h01);

        // IRQ, clear without overlap, clear coinciding with the last overlap cycle
        reg_wr(8'h45, 1);
        check("t4_irq_on", 32'(collision_irq), 1);
        reg_wr(8'h08, 250);
        scan_line(50, 195, 265, 197, 8'h44, 0, -1, 0, 0, 1'b0);
        reg_rd(8'h40, rd); check("t4_clr_lat", 32'(rd), 0);
        check("t4_clr_irq", 32'(collision_irq), 0);
        reg_wr(8'h08, 204);
        scan_line(51, 195, 215, 208, 8'h44, 0, -1, 0, 0, 1'b0);
        reg_rd(8'h40, rd); check("t4_setwins", 32'(rd), 32'h01);
        check("t4_irq_again", 32'(collision_irq), 1);

        // Move posx to 300 mid-shift: current bits finish, then a new strobe at 300
        reg_wr(8'h44, 0);
        reg_wr(8'h0E, 0);
        set_obj(0, 100, 50, 4, 8'hA5, 8'h81, 8'hAA);
        scan_line(50, 95, 330, 104, 8'h01, 8'h01, 105, 8'h00, 8'h2C, 1'b0);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("t5_old_c%0d", 100 + c), 32'(cap_vld[100+c]), 32'(pat[7 - c / 2]));
            check($sformatf("t5_new_c%0d", 300 + c), 32'(cap_vld[300+c]), 32'(pat[7 - c / 2]));
        end
        check("t5_c116", 32'(cap_vld[116]), 0);

        // Restart from bit 7 when strobed again during an active shift
        reg_wr(8'h01, 0); reg_wr(8'h00, 100); reg_wr(8'h05, 8'hF0); reg_wr(8'h06, 8'h83);
        scan_line(50, 95, 190, 105, 8'h00, 120, -1, 0, 0, 1'b0);
        check("t5r_c140", 32'(cap_vld[140]), 1);
        check("t5r_c151", 32'(cap_vld[151]), 1);
        check("t5r_c152", 32'(cap_vld[152]), 0);
        check("t5r_c183", 32'(cap_vld[183]), 0);

        // Asynchronous reset mid-shift with a latch set and irq enabled
        reg_wr(8'h00, 100); reg_wr(8'h05, 8'hFF);
        reg_wr(8'h08, 102); reg_wr(8'h0E, 8'h80);
        for (int h = 95; h <= 112; h++) begin
            @(negedge clk);
            hpos = 10'(h); vpos = 10'd50; in_image = 1'b1;
        end
        check("pre_rst_vld", 32'(pixel_valid), 1);
        check("pre_rst_irq", 32'(collision_irq), 1);
        check("pre_rst_rdata", 32'(reg_data_out), 32'h01);
        #2 reset_n = 1'b0;
        #1;
        check("arst_vld", 32'(pixel_valid), 0);
        check("arst_col", 32'(pixel_color), 0);
        check("arst_irq", 32'(collision_irq), 0);
        check("arst_rdata", 32'(reg_data_out), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1; in_image = 1'b0; hpos = 0;

        // Unmapped and unused addresses
        reg_rd(8'h38, rd); check("rd_obj7", 32'(rd), 0);
        reg_rd(8'h7F, rd); check("rd_7f", 32'(rd), 0);
        reg_wr(8'h3E, 8'h80);
        reg_rd(8'h3E, rd); check("rd_3e", 32'(rd), 0);
        scan_line(0, 0, 30, -1, 0, 0, -1, 0, 0, 1'b0);
        cnt = 0;
        for (int c = 0; c <= 30; c++) cnt += int'(cap_vld[c]);
        check("unused_wr_blank", 32'(cnt), 0);

        // Randomized objects, mid-line writes and visible-area gaps
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < NOBJ; n++)
                set_obj(n, $urandom_range(10, 60), $urandom_range(0, 4), $urandom_range(0, 6),
                        $urandom_range(0, 255), ($urandom_range(0, 255) & 8'h0B) |
                        (($urandom_range(0, 3) != 0) ? 8'h80 : 8'h00), $urandom_range(0, 255));
            reg_wr(8'h45, $urandom_range(0, 1));
            for (int v = 0; v < 8; v++) begin
                scan_line(v, 0, 95, $urandom_range(0, 95), $urandom_range(0, 8'h47), $urandom_range(0, 255),
                          -1, 0, 0, 1'b1);
                reg_rd($urandom_range(0, 8'h47), rd);
                reg_rd(8'h40, rd);
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
